ad7606_uart_frame: RTL

Downstream consumer of the AD7606 capture stage. When a conversion result set is complete, it snapshots all eight 16-bit channel words. It then serialises them as a fixed 19-byte framed packet on an 8N1 UART line for the host link. An optional decimation setting sends only every Nth result set. Result sets that arrive while a packet is still being transmitted are dropped and counted.

---
 rtl/ad7606_uart_frame.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/ad7606_uart_frame.sv
// Snapshots eight AD7606 channel words and sends them as a 19-byte
// 8N1 UART frame: AA 55, ch1..ch8 big-endian, mod-256 byte checksum.
module ad7606_uart_frame #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200,
    parameter int DECIM    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_valid,
    input  logic [15:0] ad_ch1,
    input  logic [15:0] ad_ch2,
    input  logic [15:0] ad_ch3,
    input  logic [15:0] ad_ch4,
    input  logic [15:0] ad_ch5,
    input  logic [15:0] ad_ch6,
    input  logic [15:0] ad_ch7,
    input  logic [15:0] ad_ch8,
    output logic        uart_tx,
    output logic        busy,
    output logic [7:0]  drop_cnt
);

    localparam int BIT_DIV = CLK_FREQ / BAUD;
    localparam int CW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam logic [CW-1:0] BIT_LAST = CW'(BIT_DIV - 1);
    localparam logic [7:0] DEC_LAST = 8'(DECIM - 1);
    localparam logic [4:0] BYTE_LAST = 5'd18;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [4:0]    byte_q, byte_d;
    logic [7:0]    dec_q, dec_d;
    logic [7:0]    drop_q, drop_d;
    logic [127:0]  snap_q, snap_d;
    logic [7:0]    csum_q, csum_d;
    logic          tx_q, tx_d;

    logic          req;
    logic          accept;
    logic          bit_end;
    logic [127:0]  in_vec;
    logic [7:0]    csum_in;
    logic [7:0]    cur_byte;
    logic [3:0]    dsel;

    assign in_vec = {ad_ch1, ad_ch2, ad_ch3, ad_ch4,
                     ad_ch5, ad_ch6, ad_ch7, ad_ch8};

    assign busy     = (state_q != S_IDLE);
    assign uart_tx  = tx_q;
    assign drop_cnt = drop_q;

    always_comb begin
        csum_in = 8'h00;
        for (int i = 0; i < 16; i++) begin
            csum_in = csum_in + in_vec[8*i +: 8];
        end
    end

    // Decimation, accept/drop decision and snapshot capture
    always_comb begin
        dec_d = dec_q;
        req   = 1'b0;
        if (frame_valid) begin
            if (dec_q == DEC_LAST) begin
                dec_d = 8'h00;
                req   = 1'b1;
            end else begin
                dec_d = dec_q + 8'd1;
            end
        end
        accept = req && (state_q == S_IDLE);
        drop_d = drop_q;
        if (req && (state_q != S_IDLE) && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
        snap_d = accept ? in_vec : snap_q;
        csum_d = accept ? csum_in : csum_q;
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        bit_end = (baud_q == BIT_LAST);
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_START;
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    byte_d  = 5'd0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            default: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (byte_q == BYTE_LAST) begin
                        state_d = S_IDLE;
                        byte_d  = 5'd0;
                    end else begin
                        state_d = S_START;
                        byte_d  = byte_q + 5'd1;
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
        endcase
    end

    // Line level is derived from the next state so uart_tx is a clean flop
    always_comb begin
        dsel = 4'(byte_d - 5'd2);
        if (byte_d == 5'd0) begin
            cur_byte = 8'hAA;
        end else if (byte_d == 5'd1) begin
            cur_byte = 8'h55;
        end else if (byte_d == BYTE_LAST) begin
            cur_byte = csum_q;
        end else begin
            cur_byte = snap_q[{~dsel, 3'b000} +: 8];
        end
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = cur_byte[bit_d];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            byte_q  <= 5'd0;
            dec_q   <= 8'h00;
            drop_q  <= 8'h00;
            snap_q  <= '0;
            csum_q  <= 8'h00;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            dec_q   <= dec_d;
            drop_q  <= drop_d;
            snap_q  <= snap_d;
            csum_q  <= csum_d;
            tx_q    <= tx_d;
        end
    end

endmodule
